prbs_checker: RTL
=================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 The block SHALL take parameter CNT_W, default 32, as the width of the error and bit counters.
REQ-002 The block SHALL take parameter WIN_LEN, default 64, as the length in checked bits of the loss-of-lock window.
REQ-003 The block SHALL take parameter LOSS_ERRS, default 8, as the number of errors within one window that forces relock.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 selects PRBS7 (x^7+x^6+1); any other value selects PRBS9 (x^9+x^5+1).
REQ-007 The block SHALL have port en, input, 1 bit: checker enable.
REQ-008 The block SHALL have port data_in, input, 1 bit: received serial bit.
REQ-009 The block SHALL have port data_valid, input, 1 bit: data_in is sampled this cycle.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous clear of the counters and sticky flag.
REQ-011 The block SHALL have port locked, output, 1 bit: the block is in CHECK state.
REQ-012 The block SHALL have port err_pulse, output, 1 bit: single-cycle pulse per mismatched bit.
REQ-013 The block SHALL have port error_count, output, CNT_W bits: mismatches counted while locked.
REQ-014 The block SHALL have port bit_count, output, CNT_W bits: bits checked while locked.
REQ-015 The block SHALL have port err_sticky, output, 1 bit: at least one error since the last clear or reset.

Function
REQ-016 The block SHALL implement FSM states IDLE, SEED and CHECK.
REQ-017 IDLE SHALL go to SEED when en=1; any state SHALL return to IDLE within one cycle when en=0.
REQ-018 In SEED, each valid bit SHALL shift into local state s, LSB in, shifting left; after N valid bits (N=7 for PRBS7, N=9 for PRBS9) the FSM SHALL go to CHECK.
REQ-019 If the N captured bits are all zero, the FSM SHALL remain in SEED and restart the N-bit capture.
REQ-020 In CHECK, the predicted bit SHALL be s[6]^s[5] for PRBS7 and s[8]^s[4] for PRBS9, and s SHALL shift in the predicted bit, not data_in.
REQ-021 A valid bit in CHECK with data_in != predicted SHALL assert err_pulse on the following cycle, and error_count SHALL increment on that same edge.
REQ-022 Each valid bit in CHECK SHALL increment bit_count.
REQ-023 Both counters SHALL saturate at all-ones and never wrap.
REQ-024 Cycles with data_valid=0 SHALL leave s, the counters and the window unchanged.
REQ-025 A window counter SHALL count valid CHECK bits modulo WIN_LEN, with a per-window error tally.
REQ-026 When the window tally reaches LOSS_ERRS, the FSM SHALL go to SEED next cycle, and the window SHALL be reset.
REQ-027 On a change of mode while in SEED or CHECK, the FSM SHALL restart SEED next cycle; the bit arriving on that cycle SHALL be discarded.
REQ-028 clear SHALL zero error_count, bit_count and err_sticky; if clear coincides with an increment, clear wins.
REQ-029 clear SHALL NOT affect the FSM state or lock.
REQ-030 locked SHALL be registered and high exactly while the state is CHECK.
REQ-031 err_sticky SHALL set together with err_pulse.

Reset
REQ-032 When reset_n=0, the state SHALL be IDLE, s=0, the window count and tally SHALL be 0, and locked, err_pulse, err_sticky, error_count and bit_count SHALL all be 0, asynchronously.
REQ-033 Deassertion of reset_n SHALL be the only route out of reset, and reset mid-CHECK SHALL discard lock.

Structure
REQ-034 Package prbs_pkg SHALL hold the mode encodings, the PRBS7/PRBS9 lengths and tap indices, and the FSM state enum.
REQ-035 A sub-module prbs_lfsr_step (combinational next-state/predicted-bit for the selected mode) SHALL be instantiated once.

Verification
REQ-036 Clean PRBS7 stream from seed 7'h7F, en=1 -> locked high after 7 valid bits plus 1 cycle; 1000 bits -> error_count=0, bit_count=1000.
REQ-037 PRBS9 stream with bit 100 inverted after lock -> exactly one err_pulse and error_count=1; err_sticky=1 until clear.
REQ-038 All-zero input for 50 bits -> locked stays 0.
REQ-039 Random data after lock -> the FSM returns to SEED once 8 errors occur within 64 bits, then relocks onto a subsequent valid PRBS.
REQ-040 With CNT_W=4, feed 20 errored bits -> error_count holds at 15; clear and error in the same cycle -> count 0.
REQ-041 Toggle mode 00->01 mid-CHECK, then assert reset_n=0 mid-SEED -> unlock next cycle; all outputs return to 0 immediately on reset.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS7/PRBS9 serial checker: mode encodings,
// polynomial lengths and taps, FSM state type and seed-capture helpers.
package prbs_pkg;

  localparam int unsigned MODE_W      = 2;
  localparam logic [MODE_W-1:0] MODE_PRBS7 = 2'b00;
  localparam logic [MODE_W-1:0] MODE_PRBS9 = 2'b01;

  localparam int unsigned PRBS7_LEN   = 7;
  localparam int unsigned PRBS9_LEN   = 9;
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 5;
  localparam int unsigned PRBS9_TAP_A = 8;
  localparam int unsigned PRBS9_TAP_B = 4;

  localparam int unsigned LFSR_W      = PRBS9_LEN;
  localparam int unsigned SEED_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Index of the last seed bit for the selected polynomial
  function automatic logic [SEED_CNT_W-1:0] seed_last(input logic prbs9);
    return prbs9 ? SEED_CNT_W'(PRBS9_LEN - 1) : SEED_CNT_W'(PRBS7_LEN - 1);
  endfunction

  // Bits of the LFSR that hold a captured seed for the selected polynomial
  function automatic logic [LFSR_W-1:0] seed_mask(input logic prbs9);
    return prbs9 ? LFSR_W'((1 << PRBS9_LEN) - 1) : LFSR_W'((1 << PRBS7_LEN) - 1);
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// One step of the self-synchronised reference LFSR: predicted bit for the
// selected polynomial and the state with that prediction shifted in.
module prbs_lfsr_step
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] s,
  input  logic              prbs9,
  output logic              pred_c,
  output logic [LFSR_W-1:0] next_c
);

  always_comb begin
    pred_c = prbs9 ? (s[PRBS9_TAP_A] ^ s[PRBS9_TAP_B])
                   : (s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]);
    next_c = {s[LFSR_W-2:0], pred_c};
  end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS7/PRBS9 checker: seeds a local LFSR from the received stream,
// then free-runs it and counts mismatches, relocking on bursts of errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WIN_LEN   = 64,
  parameter int unsigned LOSS_ERRS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [MODE_W-1:0] mode,
  input  logic              en,
  input  logic              data_in,
  input  logic              data_valid,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  error_count,
  output logic [CNT_W-1:0]  bit_count,
  output logic              err_sticky
);

  localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned TAL_W = $clog2(LOSS_ERRS + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [TAL_W-1:0] TAL_MAX  = TAL_W'(LOSS_ERRS);

  state_t                  state, state_d;
  logic [LFSR_W-1:0]       s, s_d, step_c;
  logic [SEED_CNT_W-1:0]   seed_cnt, seed_cnt_d;
  logic [WIN_W-1:0]        win_cnt, win_cnt_d;
  logic [TAL_W-1:0]        win_errs, win_errs_d, tally;
  logic [MODE_W-1:0]       mode_q;
  logic [CNT_W-1:0]        err_cnt_d, bit_cnt_d;
  logic                    err_d, sticky_d, locked_d;
  logic                    prbs9, mode_chg, pred_c, mism, restart;

  assign prbs9    = (mode != MODE_PRBS7);
  assign mode_chg = (mode != mode_q);

  prbs_lfsr_step u_step (
    .s      (s),
    .prbs9  (prbs9),
    .pred_c (pred_c),
    .next_c (step_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    s_d        = s;
    seed_cnt_d = seed_cnt;
    win_cnt_d  = win_cnt;
    win_errs_d = win_errs;
    err_d      = 1'b0;
    err_cnt_d  = error_count;
    bit_cnt_d  = bit_count;
    sticky_d   = err_sticky;
    mism       = 1'b0;
    tally      = win_errs;
    restart    = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: restart = 1'b1;
        ST_SEED: begin
          if (mode_chg) begin
            restart = 1'b1;
          end else if (data_valid) begin
            s_d = {s[LFSR_W-2:0], data_in};
            if (seed_cnt == seed_last(prbs9)) begin
              seed_cnt_d = '0;
              // an all-zero seed would lock the LFSR at zero; capture again
              if ((s_d & seed_mask(prbs9)) != '0) state_d = ST_CHECK;
            end else begin
              seed_cnt_d = seed_cnt + SEED_CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (mode_chg) begin
            restart = 1'b1;
          end else if (data_valid) begin
            mism  = data_in ^ pred_c;
            s_d   = step_c;
            err_d = mism;
            tally = win_errs + TAL_W'(mism);
            if (mism) begin
              sticky_d = 1'b1;
              if (error_count != '1) err_cnt_d = error_count + CNT_W'(1);
            end
            if (bit_count != '1) bit_cnt_d = bit_count + CNT_W'(1);
            if (tally >= TAL_MAX) begin
              restart = 1'b1;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt_d  = '0;
              win_errs_d = '0;
            end else begin
              win_cnt_d  = win_cnt + WIN_W'(1);
              win_errs_d = tally;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (restart) begin
      state_d    = ST_SEED;
      seed_cnt_d = '0;
      win_cnt_d  = '0;
      win_errs_d = '0;
    end

    if (clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
      sticky_d  = 1'b0;
    end

    locked_d = (state_d == ST_CHECK);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      s           <= '0;
      seed_cnt    <= '0;
      win_cnt     <= '0;
      win_errs    <= '0;
      mode_q      <= MODE_PRBS7;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      error_count <= '0;
      bit_count   <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= state_d;
      s           <= s_d;
      seed_cnt    <= seed_cnt_d;
      win_cnt     <= win_cnt_d;
      win_errs    <= win_errs_d;
      mode_q      <= mode;
      locked      <= locked_d;
      err_pulse   <= err_d;
      error_count <= err_cnt_d;
      bit_count   <= bit_cnt_d;
      err_sticky  <= sticky_d;
    end
  end

endmodule
